// File: rtl/calendar_ctrl.sv
// calendar_ctrl: date registers advanced by midnight ticks and edited from the
// push button with auto-repeat, including days-in-month and leap-year handling.
module calendar_ctrl #(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       day_tick,
    input  logic       calenderon,
    input  logic       yset,
    input  logic       monset,
    input  logic       dset,
    input  logic       wset,
    input  logic       up,
    output logic [6:0] year,
    output logic [3:0] month,
    output logic [4:0] day,
    output logic [2:0] weekday,
    output logic       busy,
    output logic       edit_pulse
);
    typedef enum logic [2:0] {IDLE, ADV_DAY, ADV_MON, ADV_YEAR, CLAMP} state_t;

    state_t      r_state, w_next;
    logic        r_up, r_pend;
    logic [31:0] r_cnt, w_cnt_inc;
    logic        w_rise, w_event, w_edit, w_tick, w_wrap;
    logic [4:0]  w_dim;

    function automatic logic [4:0] dim(input logic [3:0] m, input logic [6:0] y);
        return (m == 4'd2) ? ((y[1:0] == 2'd0) ? 5'd29 : 5'd28) :
               (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    assign w_dim     = dim(month, year);
    assign w_cnt_inc = r_cnt + 32'd1;
    // the counter folds back to REPEAT_DELAY so each period ends on the same compare
    assign w_wrap    = w_cnt_inc == REPEAT_DELAY + REPEAT_PERIOD;
    assign w_rise    = up & ~r_up;
    assign w_event   = w_rise | (up & r_up & (w_cnt_inc == REPEAT_DELAY || w_wrap));
    assign w_edit    = (r_state == IDLE) & ~calenderon & $onehot({yset, monset, dset, wset}) & w_event;
    assign w_tick    = day_tick | r_pend;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_tick && calenderon) ? ADV_DAY :
                              (w_edit && (yset || monset)) ? CLAMP : IDLE;
            ADV_DAY: w_next = (day == w_dim) ? ADV_MON : IDLE;
            ADV_MON: w_next = (month == 4'd12) ? ADV_YEAR : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            year       <= 7'd24;
            month      <= 4'd1;
            day        <= 5'd1;
            weekday    <= 3'd1;
            busy       <= 1'b0;
            edit_pulse <= 1'b0;
            r_up       <= 1'b0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_up       <= up;
            r_cnt      <= (!up || w_rise) ? '0 : w_wrap ? REPEAT_DELAY : w_cnt_inc;
            edit_pulse <= w_edit;
            busy       <= w_next inside {ADV_DAY, ADV_MON, ADV_YEAR};
            r_pend     <= (r_state == IDLE) ? 1'b0 : (r_pend | day_tick);
            case (r_state)
                IDLE: if (w_edit) begin
                    if (yset)   year    <= (year == 7'd99) ? 7'd0 : year + 7'd1;
                    if (monset) month   <= (month == 4'd12) ? 4'd1 : month + 4'd1;
                    if (dset)   day     <= (day >= w_dim) ? 5'd1 : day + 5'd1;
                    if (wset)   weekday <= (weekday == 3'd6) ? 3'd0 : weekday + 3'd1;
                end
                ADV_DAY: begin
                    weekday <= (weekday == 3'd6) ? 3'd0 : weekday + 3'd1;
                    day     <= (day == w_dim) ? 5'd1 : day + 5'd1;
                end
                ADV_MON:  month <= (month == 4'd12) ? 4'd1 : month + 4'd1;
                ADV_YEAR: year  <= (year == 7'd99) ? 7'd0 : year + 7'd1;
                CLAMP:    if (day > w_dim) day <= w_dim;
            endcase
        end
    end
endmodule

// File: tb/tb_calendar_ctrl.sv
// tb_calendar_ctrl: scenario tasks plus randomized ticks/edits checked against
// a calendar-arithmetic reference model.
module tb_calendar_ctrl;
    localparam int D = 8;
    localparam int P = 4;

    logic clk = 0, reset = 0, day_tick = 0, calenderon = 0;
    logic yset = 0, monset = 0, dset = 0, wset = 0, up = 0;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic [2:0] weekday;
    logic       busy, edit_pulse;

    int errors = 0, checks = 0;
    int my = 24, mm = 1, md = 1, mw = 1;

    always #5 clk = ~clk;

    calendar_ctrl #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
        .clk(clk), .reset(reset), .day_tick(day_tick), .calenderon(calenderon),
        .yset(yset), .monset(monset), .dset(dset), .wset(wset), .up(up),
        .year(year), .month(month), .day(day), .weekday(weekday),
        .busy(busy), .edit_pulse(edit_pulse)
    );

    function automatic int mdim(int m, int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic bit is_event(int i);
        return i == 0 || (i >= D && (i - D) % P == 0);
    endfunction

    task automatic model_edit(input logic [3:0] sel);
        if ($countones(sel) != 1) return;
        if (sel[3]) my = (my + 1) % 100;
        if (sel[2]) mm = mm % 12 + 1;
        if (sel[1]) md = (md >= mdim(mm, my)) ? 1 : md + 1;
        if (sel[0]) mw = (mw + 1) % 7;
        if (md > mdim(mm, my)) md = mdim(mm, my);
    endtask

    task automatic model_next_day(output int nb);
        nb = 1;
        mw = (mw + 1) % 7;
        if (md == mdim(mm, my)) begin
            md = 1;
            nb = 2;
            if (mm == 12) begin mm = 1; my = (my + 1) % 100; nb = 3; end
            else mm++;
        end else md++;
    endtask

    task automatic press(input logic [3:0] sel);
        @(negedge clk); {yset, monset, dset, wset} = sel; up = 1;
        @(negedge clk); up = 0;
        @(negedge clk); {yset, monset, dset, wset} = 4'b0;
        model_edit(sel);
    endtask

    task automatic load(input int y, input int m, input int d, input int w);
        calenderon = 0;
        for (int i = 0; i < 100 && my != y; i++) press(4'b1000);
        for (int i = 0; i < 12 && mm != m; i++) press(4'b0100);
        for (int i = 0; i < 31 && md != d; i++) press(4'b0010);
        for (int i = 0; i < 7 && mw != w; i++) press(4'b0001);
        checks++;
        if ({year, month, day, weekday} !== {7'(y), 4'(m), 5'(d), 3'(w)}) begin
            errors++;
            $display("FAIL load: got %0d/%0d/%0d wd%0d, want %0d/%0d/%0d wd%0d", year, month, day, weekday, y, m, d, w);
        end
    endtask

    task automatic do_tick(input string name);
        int exp_nb, nb;
        calenderon = 1;
        model_next_day(exp_nb);
        @(negedge clk); day_tick = 1;
        @(negedge clk); day_tick = 0;
        nb = 0;
        while (busy && nb < 8) begin nb++; @(negedge clk); end
        checks++;
        if (nb != exp_nb) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d, want %0d", name, nb, exp_nb);
        end
        checks++;
        if ({year, month, day, weekday} !== {7'(my), 4'(mm), 5'(md), 3'(mw)}) begin
            errors++;
            $display("FAIL %s date: got %0d/%0d/%0d wd%0d, want %0d/%0d/%0d wd%0d", name, year, month, day, weekday, my, mm, md, mw);
        end
    endtask

    task automatic test_reset;
        reset = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({year, month, day, weekday, busy, edit_pulse} !== {7'd24, 4'd1, 5'd1, 3'd1, 2'b00}) begin
            errors++;
            $display("FAIL reset_held: got %0d/%0d/%0d wd%0d busy%0b ep%0b, want 24/1/1 wd1 busy0 ep0", year, month, day, weekday, busy, edit_pulse);
        end
        reset = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({year, month, day, weekday, busy, edit_pulse} !== {7'd24, 4'd1, 5'd1, 3'd1, 2'b00}) begin
            errors++;
            $display("FAIL reset_release: got %0d/%0d/%0d wd%0d busy%0b ep%0b, want 24/1/1 wd1 busy0 ep0", year, month, day, weekday, busy, edit_pulse);
        end
    endtask

    task automatic test_leap;
        load(24, 2, 28, 3);
        do_tick("leap_29");
        checks++;
        if ({year, month, day, weekday} !== {7'd24, 4'd2, 5'd29, 3'd4}) begin
            errors++;
            $display("FAIL leap_29 const: got %0d/%0d/%0d wd%0d, want 24/2/29 wd4", year, month, day, weekday);
        end
        do_tick("leap_mar1");
        checks++;
        if ({year, month, day, weekday} !== {7'd24, 4'd3, 5'd1, 3'd5}) begin
            errors++;
            $display("FAIL leap_mar1 const: got %0d/%0d/%0d wd%0d, want 24/3/1 wd5", year, month, day, weekday);
        end
    endtask

    task automatic test_century;
        int nb;
        load(99, 12, 31, 4);
        calenderon = 1;
        @(negedge clk); day_tick = 1;
        @(negedge clk); day_tick = 0;
        checks++;
        if (busy !== 1'b1 || day !== 5'd31) begin
            errors++;
            $display("FAIL century_k: got busy%0b day%0d, want busy1 day31", busy, day);
        end
        @(negedge clk);
        checks++;
        if (day !== 5'd1 || weekday !== 3'd5 || month !== 4'd12 || busy !== 1'b1) begin
            errors++;
            $display("FAIL century_k1: got day%0d wd%0d mon%0d busy%0b, want day1 wd5 mon12 busy1", day, weekday, month, busy);
        end
        @(negedge clk);
        checks++;
        if (month !== 4'd1 || year !== 7'd99 || busy !== 1'b1) begin
            errors++;
            $display("FAIL century_k2: got mon%0d year%0d busy%0b, want mon1 year99 busy1", month, year, busy);
        end
        @(negedge clk);
        checks++;
        if (year !== 7'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL century_k3: got year%0d busy%0b, want year0 busy0", year, busy);
        end
        model_next_day(nb);
        checks++;
        if ({year, month, day, weekday} !== {7'(my), 4'(mm), 5'(md), 3'(mw)} || nb != 3) begin
            errors++;
            $display("FAIL century_model: got %0d/%0d/%0d wd%0d, want %0d/%0d/%0d wd%0d", year, month, day, weekday, my, mm, md, mw);
        end
    endtask

    task automatic test_clamp;
        int want_m, want_d;
        for (int t = 0; t < 2; t++) begin
            want_m = (t == 0) ? 4 : 2;
            want_d = (t == 0) ? 30 : 28;
            load(23, (t == 0) ? 3 : 1, 31, mw);
            @(negedge clk); monset = 1; up = 1;
            @(negedge clk); up = 0;
            checks++;
            if (month !== 4'(want_m) || edit_pulse !== 1'b1 || day !== 5'd31) begin
                errors++;
                $display("FAIL clamp%0d_k: got mon%0d ep%0b day%0d, want mon%0d ep1 day31", t, month, edit_pulse, day, want_m);
            end
            @(negedge clk); monset = 0;
            checks++;
            if (day !== 5'(want_d) || edit_pulse !== 1'b0) begin
                errors++;
                $display("FAIL clamp%0d_k1: got day%0d ep%0b, want day%0d ep0", t, day, edit_pulse, want_d);
            end
            model_edit(4'b0100);
        end
    endtask

    task automatic test_repeat;
        logic [31:0] mask;
        int cnt;
        load(my, mm, 1, mw);
        mask = 0;
        @(negedge clk); dset = 1; up = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (edit_pulse) mask[i] = 1'b1;
        end
        up = 0;
        @(negedge clk);
        checks++;
        if (mask !== 32'h0001_1101 || day !== 5'd5) begin
            errors++;
            $display("FAIL repeat_hold: got mask %h day%0d, want mask 00011101 day5", mask, day);
        end
        cnt = 0;
        up = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (edit_pulse) cnt++;
        end
        up = 0;
        @(negedge clk); dset = 0;
        checks++;
        if (cnt != 1 || day !== 5'd6) begin
            errors++;
            $display("FAIL repeat_repress: got %0d pulses day%0d, want 1 pulse day6", cnt, day);
        end
        md = 6;
    endtask

    task automatic test_pending;
        int nb;
        load(24, 12, 31, mw);
        calenderon = 1;
        @(negedge clk); day_tick = 1;
        @(negedge clk); day_tick = 1;
        @(negedge clk); day_tick = 0;
        repeat (10) @(negedge clk);
        model_next_day(nb);
        model_next_day(nb);
        checks++;
        if ({year, month, day, weekday} !== {7'd25, 4'd1, 5'd2, 3'(mw)}) begin
            errors++;
            $display("FAIL pending: got %0d/%0d/%0d wd%0d, want 25/1/2 wd%0d", year, month, day, weekday, mw);
        end
    endtask

    task automatic test_mid_reset;
        load(my, mm, 31, mw);
        calenderon = 1;
        @(negedge clk); day_tick = 1;
        @(negedge clk); day_tick = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || day !== 5'd1) begin
            errors++;
            $display("FAIL midreset_pre: got busy%0b day%0d, want busy1 day1", busy, day);
        end
        reset = 0;
        #1;
        checks++;
        if ({year, month, day, weekday, busy, edit_pulse} !== {7'd24, 4'd1, 5'd1, 3'd1, 2'b00}) begin
            errors++;
            $display("FAIL midreset_now: got %0d/%0d/%0d wd%0d busy%0b ep%0b, want 24/1/1 wd1 busy0 ep0", year, month, day, weekday, busy, edit_pulse);
        end
        @(negedge clk); reset = 1;
        my = 24; mm = 1; md = 1; mw = 1;
        repeat (4) @(negedge clk);
        checks++;
        if ({year, month, day, weekday, busy} !== {7'd24, 4'd1, 5'd1, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL midreset_after: got %0d/%0d/%0d wd%0d busy%0b, want 24/1/1 wd1 busy0", year, month, day, weekday, busy);
        end
    endtask

    task automatic test_random;
        int op, len, cnt, exp_cnt;
        logic [3:0] sel;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                if ($urandom_range(0, 1) == 1) load(my, mm, mdim(mm, my), mw);
                do_tick("rand_tick");
            end else if (op == 1) begin
                calenderon = 0;
                sel = 4'($urandom_range(0, 15));
                @(negedge clk); {yset, monset, dset, wset} = sel; up = 1;
                @(negedge clk); up = 0;
                checks++;
                if (edit_pulse !== $onehot(sel)) begin
                    errors++;
                    $display("FAIL rand_edit_pulse: sel %b got %0b, want %0b", sel, edit_pulse, $onehot(sel));
                end
                @(negedge clk); {yset, monset, dset, wset} = 4'b0;
                model_edit(sel);
                checks++;
                if ({year, month, day, weekday} !== {7'(my), 4'(mm), 5'(md), 3'(mw)}) begin
                    errors++;
                    $display("FAIL rand_edit sel %b: got %0d/%0d/%0d wd%0d, want %0d/%0d/%0d wd%0d", sel, year, month, day, weekday, my, mm, md, mw);
                end
            end else if (op == 2) begin
                calenderon = 0;
                @(negedge clk); day_tick = 1;
                @(negedge clk); day_tick = 0;
                @(negedge clk);
                checks++;
                if ({year, month, day, weekday, busy} !== {7'(my), 4'(mm), 5'(md), 3'(mw), 1'b0}) begin
                    errors++;
                    $display("FAIL rand_setmode_tick: got %0d/%0d/%0d wd%0d busy%0b, want %0d/%0d/%0d wd%0d busy0", year, month, day, weekday, busy, my, mm, md, mw);
                end
            end else begin
                calenderon = 0;
                sel = 4'($urandom_range(0, 15));
                len = $urandom_range(1, 24);
                cnt = 0;
                exp_cnt = 0;
                @(negedge clk); {yset, monset, dset, wset} = sel; up = 1;
                for (int i = 0; i < len; i++) begin
                    @(negedge clk);
                    if (edit_pulse) cnt++;
                    if (is_event(i) && $onehot(sel)) begin exp_cnt++; model_edit(sel); end
                end
                up = 0;
                @(negedge clk); {yset, monset, dset, wset} = 4'b0;
                checks++;
                if (cnt != exp_cnt || {year, month, day, weekday} !== {7'(my), 4'(mm), 5'(md), 3'(mw)}) begin
                    errors++;
                    $display("FAIL rand_hold sel %b len %0d: got %0d pulses %0d/%0d/%0d wd%0d, want %0d pulses %0d/%0d/%0d wd%0d", sel, len, cnt, year, month, day, weekday, exp_cnt, my, mm, md, mw);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_leap;
        test_century;
        test_clamp;
        test_repeat;
        test_pending;
        test_mid_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calendar_ctrl.md
# calendar_ctrl

Calendar register and sequencing controller for the digital clock. It advances day, weekday, month and year on each midnight pulse from the time-of-day counter, with days-in-month and leap-year handling. It also applies set-mode increments from the push button, with auto-repeat, to whichever field the mode FSM selects. The block sits between the mode FSM (`calenderon`, `yset`/`monset`/`dset`/`wset`) and the display mux.

## Interface
Parameters:
- `REPEAT_DELAY`, default 50_000_000: cycles `up` must stay held after the first increment before auto-repeat starts.
- `REPEAT_PERIOD`, default 12_500_000: cycles between auto-repeat increments.

Ports:
- `clk` in 1: system clock. Everything is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `day_tick` in 1: one-cycle pulse from the time counter at the 23:59→00:00 rollover.
- `calenderon` in 1: run enable. 1 = normal running, 0 = set mode.
- `yset`, `monset`, `dset`, `wset` in 1 each: field selects, one-hot or all zero.
- `up` in 1: debounced, synchronized increment-button level.
- `year` out 7: 0..99, representing 2000..2099.
- `month` out 4: 1..12.
- `day` out 5: 1..31.
- `weekday` out 3: 0..6, with 0 = Sunday.
- `busy` out 1: high while a rollover sequence is in progress.
- `edit_pulse` out 1: one-cycle pulse per applied increment.

## Operation
- Reset values (asynchronous, while `reset`=0):
  - `year`=24, `month`=1, `day`=1, `weekday`=1 (2024-01-01, a Monday).
  - `busy`=0, `edit_pulse`=0.
  - State IDLE, pending flag cleared, repeat counter cleared.
- Days-in-month, dim(month, year):
  - 30 for months 4, 6, 9, 11.
  - For month 2: 29 if `year[1:0]`==0 (year 00 is a leap year), else 28.
  - 31 for all other months.
- FSM states: IDLE, ADV_DAY, ADV_MON, ADV_YEAR, CLAMP. `busy` = state ∈ {ADV_DAY, ADV_MON, ADV_YEAR}.
- IDLE:
  - `day_tick`=1 and `calenderon`=1 → ADV_DAY.
  - `day_tick` with `calenderon`=0 is discarded.
- ADV_DAY:
  - `weekday` ← (`weekday`+1) mod 7.
  - If `day`==dim: `day` ← 1, go to ADV_MON.
  - Otherwise: `day` ← `day`+1, go to IDLE.
- ADV_MON:
  - If `month`==12: `month` ← 1, go to ADV_YEAR.
  - Otherwise: `month` ← `month`+1, go to IDLE.
- ADV_YEAR: `year` ← (`year`+1) mod 100, go to IDLE.
- A `day_tick` arriving while `busy` sets a one-deep pending flag. IDLE serves the pending flag as if it were a fresh `day_tick`. A second tick while the flag is already set is dropped.
- Edit conditions. An edit is applied only when all of these hold:
  - state is IDLE,
  - `calenderon`=0,
  - exactly one of `yset`/`monset`/`dset`/`wset` is 1,
  - an increment event occurs.
  
  Otherwise the event is ignored, but the repeat counter still tracks `up`.
- Increment events:
  - A rising edge of `up` (registered `up`=0, current `up`=1) is an event, and clears the repeat counter.
  - While `up` stays at 1, the counter increments every cycle.
  - An event fires when the count reaches `REPEAT_DELAY`.
  - After that, an event fires every `REPEAT_PERIOD` cycles.
  - `up`=0 clears the counter.
- Field wraps on edit:
  - `year` 99→0.
  - `month` 12→1.
  - `day` dim→1, where a `day` already above dim also goes to 1.
  - `weekday` 6→0.
- An edit of `year` or `month` moves the FSM to CLAMP for one cycle. CLAMP sets `day` ← min(`day`, dim), then returns to IDLE. No edit is applied in CLAMP.
- Field selects are levels. A select change mid-hold does not restart the repeat counter.

## Timing
- Rollover: `day_tick` sampled at edge k.
  - `day` and `weekday` update at edge k+1.
  - `month` at edge k+2, if it wraps.
  - `year` at edge k+3, if it wraps.
  - `busy` is high for 1, 2 or 3 cycles, starting after edge k.
- Edit: the event is sampled at edge k. The field update and `edit_pulse`=1 are both registered at edge k, so `edit_pulse` is high for one cycle. The CLAMP correction lands at edge k+1.
- Repeat schedule for a hold that starts at edge 0: events at cycles 0, `REPEAT_DELAY`, `REPEAT_DELAY`+`REPEAT_PERIOD`, …
- All outputs are registered, with no combinational path from inputs.
- `reset` deassertion takes effect at the next rising edge. Asserting `reset` mid-sequence returns all outputs to their reset values immediately; no partial update survives.

## Test plan
- Reset:
  - Hold `reset`=0 and toggle `clk`, then release.
  - Outputs must read 24/1/1, `weekday`=1, `busy`=0, `edit_pulse`=0.
- Leap February:
  - Load 24/02/28 (wd 3) via edits. Set `calenderon`=1, pulse `day_tick`.
  - Result 24/02/29, wd 4, `busy` high for 1 cycle.
  - Pulse again: 24/03/01, wd 5, `busy` high for 2 cycles.
- Century wrap:
  - 99/12/31, wd 4, then `day_tick`.
  - Result 00/01/01, wd 5, `busy` high for exactly 3 cycles. `year` changes at edge k+3.
- Clamp:
  - With `calenderon`=0, 23/03/31, `monset`=1, one `up` pulse.
  - `month`=4 and `edit_pulse`=1 at edge k, `day`=30 at edge k+1.
  - Repeat with 23/01/31 → 23/02/28.
- Auto-repeat:
  - Set `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4. `dset`=1, `day`=1, hold `up` for 20 cycles.
  - Exactly 4 `edit_pulse`s at cycles 0, 8, 12, 16; `day`=5.
  - Release, press again: one immediate increment.
- Pending tick and mid-sequence reset:
  - Two `day_tick`s one cycle apart on 24/12/31: result 25/01/02.
  - Assert `reset` during ADV_MON: outputs return to reset values immediately, `busy`=0.
